// File: rtl/keypad_scan_encoder_if.sv
// keypad_scan_encoder_if
// Groups the keypad-facing and controller-facing signals of keypad_scan_encoder.
//   col_drive  [3:0]  column drive, active-low, one bit low at a time
//   row_sense  [3:0]  row inputs, active-low, asynchronous to the system clock
//   key_valid         one-cycle strobe for an accepted key
//   key_code   [3:0]  code of the last accepted key
//   ONE, THREE, FIVE, SEVEN, A, use_code, bad_key
//                     one-cycle per-key strobes, coincident with key_valid
// master: the encoder side. slave: the keypad/controller side.
interface keypad_scan_encoder_if;
  logic [3:0] col_drive;
  logic [3:0] row_sense;
  logic       key_valid;
  logic [3:0] key_code;
  logic       ONE;
  logic       THREE;
  logic       FIVE;
  logic       SEVEN;
  logic       A;
  logic       use_code;
  logic       bad_key;

  modport master (
    output col_drive, key_valid, key_code, ONE, THREE, FIVE, SEVEN, A, use_code, bad_key,
    input  row_sense
  );

  modport slave (
    input  col_drive, key_valid, key_code, ONE, THREE, FIVE, SEVEN, A, use_code, bad_key,
    output row_sense
  );
endinterface

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
// Scans a 4x4 active-low membrane keypad, synchronises and debounces the row lines and
// turns each accepted press into a single-cycle key strobe.
// Ports:
//   clk    system clock
//   RESET  asynchronous, active-high reset
//   kp     keypad_scan_encoder_if.master: col_drive out, row_sense in, key_valid/key_code
//          and the per-key strobes ONE/THREE/FIVE/SEVEN/A/use_code/bad_key out
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key every REPEAT_CYCLES.
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input logic                   clk,
  input logic                   RESET,
  keypad_scan_encoder_if.master kp
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  // One counter serves both debounce and hold-repeat timing, so size it for the longer one.
  localparam int unsigned CntMax = (REPEAT_CYCLES > DEBOUNCE_CYCLES) ? REPEAT_CYCLES
                                                                      : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [DwellW-1:0] DwellGate = DwellW'(2);
  localparam logic [CntW-1:0]   DbLast    = CntW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CntW-1:0]   RptLast   = CntW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StScan,
    StDebounce,
    StEmit,
    StHold,
    StRelease
  } state_e;

  state_e            state_q, state_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [3:0]        pat_q, pat_d;
  logic [3:0]        rs_meta_q, rs_q;

  logic       key_valid_q;
  logic [3:0] key_code_q;
  logic       one_q, three_q, five_q, seven_q, a_q, use_code_q, bad_key_q;

  logic [3:0] low;
  logic       one_low;
  logic       emit_d;
  logic [3:0] code_d;

  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] pattern);
    logic [1:0] idx;
    case (pattern)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // A single low row; two or more low rows are a ghost/multi-press and are ignored.
  assign low     = ~rs_q;
  assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    pat_d   = pat_q;
    unique case (state_q)
      StScan: begin
        // The dwell gate lets the synchroniser catch up with the newly driven column.
        if ((dwell_q >= DwellGate) && one_low) begin
          row_d   = row_index(rs_q);
          pat_d   = rs_q;
          cnt_d   = '0;
          state_d = StDebounce;
        end else if (dwell_q == DwellLast) begin
          dwell_d = '0;
          col_d   = col_q + 2'd1;
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end
      StDebounce: begin
        if (rs_q != pat_q) begin
          dwell_d = '0;
          state_d = StScan;
        end else if (cnt_q == DbLast) begin
          state_d = StEmit;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEmit: begin
        cnt_d   = '0;
        state_d = StHold;
      end
      StHold: begin
        if (rs_q == 4'hF) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rs_q == pat_q) begin
          if (cnt_q == RptLast) begin
            cnt_d   = '0;
            state_d = StEmit;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          cnt_d = '0;
        end
`endif
      end
      StRelease: begin
        if (rs_q != 4'hF) begin
          cnt_d   = '0;
          state_d = StHold;
        end else if (cnt_q == DbLast) begin
          dwell_d = '0;
          col_d   = col_q + 2'd1;
          state_d = StScan;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        dwell_d = '0;
        state_d = StScan;
      end
    endcase
  end

  // Strobes are registered off the next state so they coincide with the EMIT cycle.
  assign emit_d = (state_d == StEmit);
  assign code_d = decode_key(row_q, col_q);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= StScan;
      dwell_q     <= '0;
      cnt_q       <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      pat_q       <= 4'hF;
      rs_meta_q   <= 4'hF;
      rs_q        <= 4'hF;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      one_q       <= 1'b0;
      three_q     <= 1'b0;
      five_q      <= 1'b0;
      seven_q     <= 1'b0;
      a_q         <= 1'b0;
      use_code_q  <= 1'b0;
      bad_key_q   <= 1'b0;
    end else begin
      rs_meta_q   <= kp.row_sense;
      rs_q        <= rs_meta_q;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pat_q       <= pat_d;
      key_valid_q <= emit_d;
      if (emit_d) begin
        key_code_q <= code_d;
      end
      one_q      <= emit_d && (code_d == 4'h1);
      three_q    <= emit_d && (code_d == 4'h3);
      five_q     <= emit_d && (code_d == 4'h5);
      seven_q    <= emit_d && (code_d == 4'h7);
      a_q        <= emit_d && (code_d == 4'hA);
      use_code_q <= emit_d && (code_d == 4'hF);
      bad_key_q  <= emit_d && !((code_d == 4'h1) || (code_d == 4'h3) || (code_d == 4'h5) ||
                                (code_d == 4'h7) || (code_d == 4'hA) || (code_d == 4'hF));
    end
  end

  assign kp.col_drive = ~(4'b0001 << col_q);
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.ONE       = one_q;
  assign kp.THREE     = three_q;
  assign kp.FIVE      = five_q;
  assign kp.SEVEN     = seven_q;
  assign kp.A         = a_q;
  assign kp.use_code  = use_code_q;
  assign kp.bad_key   = bad_key_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder
// Drives a modelled 4x4 membrane keypad (pressed-key matrix answering the driven column)
// and checks every strobe against the key map and key classes.
module tb_keypad_scan_encoder;
  localparam int unsigned ScanDiv = 4;
  localparam int unsigned Db      = 8;
  localparam int unsigned Rpt     = 64;

  // Index r*4+c -> key code.
  localparam logic [3:0] KeyMap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  logic clk = 1'b0;
  logic RESET;
  logic [15:0] pressed;
  logic [3:0]  row_model;
  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] seen_q [$];

  keypad_scan_encoder_if kif ();

  keypad_scan_encoder #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_CYCLES  (Rpt)
  ) dut (
    .clk  (clk),
    .RESET(RESET),
    .kp   (kif)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kif.col_drive[c]) row_model[r] = 1'b0;
      end
    end
  end
  assign kif.row_sense = row_model;

  // Every cycle with any strobe is recorded as {key_valid, class one-hot, key_code}.
  always @(negedge clk) begin
    if (!RESET && (kif.key_valid || kif.ONE || kif.THREE || kif.FIVE || kif.SEVEN || kif.A ||
                   kif.use_code || kif.bad_key)) begin
      seen_q.push_back({kif.key_valid, kif.ONE, kif.THREE, kif.FIVE, kif.SEVEN, kif.A,
                        kif.use_code, kif.bad_key, kif.key_code});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] exp_strobe(input int pos);
    logic [3:0] code;
    logic [6:0] cls;
    code = KeyMap[pos];
    case (code)
      4'h1:    cls = 7'b1000000;
      4'h3:    cls = 7'b0100000;
      4'h5:    cls = 7'b0010000;
      4'h7:    cls = 7'b0001000;
      4'hA:    cls = 7'b0000100;
      4'hF:    cls = 7'b0000010;
      default: cls = 7'b0000001;
    endcase
    return {1'b1, cls, code};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Alternate a key between levels; seg_len 0 picks random 1..4-cycle segments.
  task automatic bounce(input int pos, input bit start_level, input int segs, input int seg_len);
    for (int s = 0; s < segs; s++) begin
      pressed[pos] = start_level ^ s[0];
      tick((seg_len == 0) ? int'($urandom_range(1, 4)) : seg_len);
    end
  endtask

  task automatic do_key(input string tag, input int pos, input int hold, input int bin,
                        input int bout, input int seg_len);
    logic [3:0] exp_col;
    exp_col = ~(4'b0001 << pos[1:0]);
    seen_q.delete();
    bounce(pos, 1'b1, bin, seg_len);
    pressed[pos] = 1'b1;
    tick(hold);
    check({tag, "_col_frozen"}, kif.col_drive, exp_col);
    bounce(pos, 1'b0, bout, seg_len);
    pressed[pos] = 1'b0;
    tick(40);
    check({tag, "_count"}, seen_q.size(), 1);
    if (seen_q.size() > 0) check({tag, "_strobe"}, seen_q[0], exp_strobe(pos));
  endtask

  initial begin
    logic [3:0] prev, cur, exp_col;
    int run;
    bit first, found;
    int pos, hold, a_hold, a_exp;

    RESET   = 1'b1;
    pressed = '0;
    tick(3);
    check("rst_col", kif.col_drive, 4'b1110);
    check("rst_strobes", {kif.key_valid, kif.ONE, kif.THREE, kif.FIVE, kif.SEVEN, kif.A,
                          kif.use_code, kif.bad_key, kif.key_code}, 0);
    RESET = 1'b0;

    // Idle scanning: rotate-left every ScanDiv cycles, no strobes.
    seen_q.delete();
    prev  = kif.col_drive;
    run   = 1;
    first = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      cur = kif.col_drive;
      check("scan_onehot", ((cur == 4'b1110) || (cur == 4'b1101) || (cur == 4'b1011) ||
                            (cur == 4'b0111)) ? 1 : 0, 1);
      if (cur != prev) begin
        check("scan_rotate", cur, {prev[2:0], prev[3]});
        if (!first) check("scan_dwell", run, ScanDiv);
        first = 1'b0;
        run   = 1;
      end else begin
        run++;
      end
      prev = cur;
    end
    check("scan_no_strobe", seen_q.size(), 0);

    // Clean '5', column frozen through release debounce.
    seen_q.delete();
    pressed[5] = 1'b1;
    tick(40);
    check("k5_col_frozen", kif.col_drive, 4'b1101);
    pressed[5] = 1'b0;
    tick(8);
    check("k5_col_rel", kif.col_drive, 4'b1101);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1);
      if (kif.col_drive != 4'b1101) found = 1'b1;
    end
    check("k5_col_next", kif.col_drive, 4'b1011);
    tick(20);
    check("k5_count", seen_q.size(), 1);
    if (seen_q.size() > 0) check("k5_strobe", seen_q[0], exp_strobe(5));

    // '1' with 3-cycle bounce on press and release.
    do_key("k1_bounce", 0, 40, 5, 5, 3);

    // '#' then '2'.
    do_key("k_hash", 14, 40, 0, 0, 0);
    do_key("k2", 1, 40, 0, 0, 0);

    // '1' and '4' together on column 0: ignored, scanning goes on.
    seen_q.delete();
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (kif.col_drive == 4'b0111) found = 1'b1;
    end
    check("ghost_scanning", found, 1);
    check("ghost_no_strobe", seen_q.size(), 0);
    pressed[0] = 1'b0;
    pressed[4] = 1'b0;
    tick(20);

    // Second key pressed during hold is ignored.
    seen_q.delete();
    pressed[5] = 1'b1;
    tick(40);
    pressed[2] = 1'b1;
    tick(30);
    pressed[5] = 1'b0;
    pressed[2] = 1'b0;
    tick(40);
    check("hold2_count", seen_q.size(), 1);
    if (seen_q.size() > 0) check("hold2_strobe", seen_q[0], exp_strobe(5));

    // Randomized presses with random bounce.
    for (int k = 0; k < 8; k++) begin
      pos  = int'($urandom_range(0, 15));
      hold = int'($urandom_range(40, 60));
      do_key("rand", pos, hold, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 0);
    end

    // RESET during debounce of 'A'.
    seen_q.delete();
    pressed[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (kif.col_drive == 4'b0111) found = 1'b1;
    end
    check("rstA_reach_col3", found, 1);
    tick(6);
    check("rstA_pre_strobe", seen_q.size(), 0);
    RESET = 1'b1;
    #1;
    check("rstA_col", kif.col_drive, 4'b1110);
    check("rstA_outs", {kif.key_valid, kif.ONE, kif.THREE, kif.FIVE, kif.SEVEN, kif.A,
                        kif.use_code, kif.bad_key, kif.key_code}, 0);
    tick(2);
    RESET = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    a_hold = 200;
    a_exp  = 3;
`else
    a_hold = 100;
    a_exp  = 1;
`endif
    tick(a_hold);
    exp_col = 4'b0111;
    check("rstA_col_frozen", kif.col_drive, exp_col);
    pressed[3] = 1'b0;
    tick(40);
    check("rstA_count", seen_q.size(), a_exp);
    foreach (seen_q[i]) check("rstA_strobe", seen_q[i], exp_strobe(3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
